// File: rtl/key_step_pulser_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_step_pulser_if
//  Description : Key-side bundle of key_step_pulser: raw button in, step
//                pulse, debounced key state and wrapping pulse count out.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_step_pulser_if;
    logic       btn;
    logic       step;
    logic       pressed;
    logic [7:0] step_count;

    // Master: whatever owns the button and consumes the pulses.
    modport master (output btn, input step, pressed, step_count);
    // Slave: the pulser itself.
    modport slave  (input btn, output step, pressed, step_count);
endinterface
`default_nettype wire

// File: rtl/key_step_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : key_step_pulser
//  Description : Turns a raw, bouncing push-button into clean one-cycle step
//                pulses with optional auto-repeat while held, a debounced key
//                state and an 8-bit wrapping count of issued pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module key_step_pulser #(
    parameter int BTN_ACTIVE      = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    key_step_pulser_if.slave  kbus
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int C_MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int C_MAX_CYC = (C_MAX_A > REPEAT_PERIOD) ? C_MAX_A : REPEAT_PERIOD;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC) + 1;

    localparam logic [C_CNT_W-1:0] C_DB_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_RD_LAST = C_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [C_CNT_W-1:0] C_RP_LAST = C_CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    localparam logic C_BTN_ACT  = (BTN_ACTIVE != 0);
    localparam logic C_BTN_IDLE = ~C_BTN_ACT;
    localparam logic C_REPEAT   = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_btn_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [C_CNT_W-1:0] w_cnt_inc;
    logic               w_step_nxt;
    logic               w_pressed_nxt;
    logic               r_step;
    logic               r_pressed;
    logic [7:0]         r_step_count;

    // Two-flop synchroniser; reset loads the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= C_BTN_IDLE;
            r_sync2 <= C_BTN_IDLE;
        end else begin
            r_sync1 <= kbus.btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s   = (r_sync2 == C_BTN_ACT);
    assign w_cnt_inc = r_cnt + C_CNT_ONE;

    // Next-state, counter and pulse decode; the counter restarts on every
    // state change and on each repeat pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_PRESS_DB;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_RD_LAST) begin
                    // Without auto-repeat the counter simply parks here.
                    if (C_REPEAT) begin
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                        w_step_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_RP_LAST) begin
                    w_cnt_nxt  = '0;
                    w_step_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RELEASE_DB: begin
                // A bounce back to pressed re-arms the repeat delay but never
                // emits a pulse of its own.
                if (w_btn_s) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_pressed_nxt = (w_state_nxt == ST_PRESSED) ||
                           (w_state_nxt == ST_REPEAT)  ||
                           (w_state_nxt == ST_RELEASE_DB);

    // State register plus registered outputs, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_step       <= 1'b0;
            r_pressed    <= 1'b0;
            r_step_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step       <= w_step_nxt;
            r_pressed    <= w_pressed_nxt;
            r_step_count <= r_step_count + {7'd0, w_step_nxt};
        end
    end

    assign kbus.step       = r_step;
    assign kbus.pressed    = r_pressed;
    assign kbus.step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_key_step_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_step_pulser
//  Description : Self-checking bench for key_step_pulser. Two instances
//                (auto-repeat on / off) share one button; a run-length
//                reference model predicts pulses into per-instance queues
//                that a negedge monitor drains and checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_step_pulser;

    localparam int D = 4;
    localparam int R = 10;
    localparam int P = 3;

    typedef struct packed {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    key_step_pulser_if bus_r ();
    key_step_pulser_if bus_n ();

    key_step_pulser #(
        .BTN_ACTIVE(1), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
        .REPEAT_DELAY(R), .REPEAT_PERIOD(P)
    ) dut_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .kbus  (bus_r)
    );

    key_step_pulser #(
        .BTN_ACTIVE(1), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
        .REPEAT_DELAY(R), .REPEAT_PERIOD(P)
    ) dut_norep (
        .clk   (clk),
        .rst_n (rst_n),
        .kbus  (bus_n)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   pulses_r = 0;
    int   pulses_n = 0;

    // Reference model state: per instance, key accepted flag, lengths of the
    // current high / low runs of the synchronised button, and time since the
    // key was (re)established as held.
    bit   h1, h2;
    bit   m_down  [2];
    int   m_ones  [2];
    int   m_zeros [2];
    int   m_age   [2];
    int   m_cnt   [2];
    bit   rep_en  [2] = '{1'b1, 1'b0};
    exp_t q_r [$];
    exp_t q_n [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) q_r.push_back(e);
        else        q_n.push_back(e);
    endtask

    // Button as seen by the pulser is the raw button two edges late. A press
    // is accepted after D+1 consecutive high samples, released after D+1
    // consecutive low samples; while held, repeats land at R, R+P, R+2P...
    // samples after the key was (re)established.
    task automatic model_step();
        bit   s;
        bit   fire;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            h1 = 1'b0;
            h2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_down[i] = 1'b0; m_ones[i] = 0; m_zeros[i] = 0;
                m_age[i] = 0; m_cnt[i] = 0;
            end
            q_r.delete();
            q_n.delete();
            return;
        end
        s  = h2;
        h2 = h1;
        h1 = bus_r.btn;
        for (int i = 0; i < 2; i++) begin
            fire = 1'b0;
            if (!m_down[i]) begin
                if (s) begin
                    m_ones[i]++;
                    if (m_ones[i] == D + 1) begin
                        m_down[i] = 1'b1; m_age[i] = 0; m_zeros[i] = 0;
                        fire = 1'b1;
                    end
                end else begin
                    m_ones[i] = 0;
                end
            end else if (s) begin
                if (m_zeros[i] > 0) begin
                    m_zeros[i] = 0;
                    m_age[i]   = 0;
                end else begin
                    m_age[i]++;
                    if (rep_en[i] && m_age[i] >= R && ((m_age[i] - R) % P) == 0)
                        fire = 1'b1;
                end
            end else begin
                m_zeros[i]++;
                if (m_zeros[i] == D + 1) begin
                    m_down[i] = 1'b0;
                    m_ones[i] = 0;
                end
            end
            if (fire) begin
                m_cnt[i] = (m_cnt[i] + 1) % 256;
                e.cyc = cyc;
                e.cnt = 8'(m_cnt[i]);
                push_exp(i, e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check_one(input int i, input logic st, input logic pr,
                             input logic [7:0] sc);
        exp_t e;
        int   n;
        n = (i == 0) ? q_r.size() : q_n.size();
        if (st === 1'b1) begin
            n_cmp++;
            if (n == 0) begin
                n_err++;
                $display("FAIL unexpected_step inst=%0d cyc=%0d actual=step required=no_step", i, cyc);
            end else begin
                e = (i == 0) ? q_r.pop_front() : q_n.pop_front();
                n--;
                if (e.cyc != cyc || e.cnt !== sc) begin
                    n_err++;
                    $display("FAIL step inst=%0d actual cyc=%0d count=%0d required cyc=%0d count=%0d",
                             i, cyc, sc, e.cyc, e.cnt);
                end
            end
        end
        if (n > 0) begin
            e = (i == 0) ? q_r[0] : q_n[0];
            if (e.cyc <= cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing_step inst=%0d actual=no_step required=step at cyc=%0d", i, e.cyc);
                if (i == 0) void'(q_r.pop_front());
                else        void'(q_n.pop_front());
            end
        end
        n_cmp++;
        if (pr !== m_down[i]) begin
            n_err++;
            $display("FAIL pressed inst=%0d cyc=%0d actual=%0b required=%0b", i, cyc, pr, m_down[i]);
        end
        n_cmp++;
        if (sc !== 8'(m_cnt[i])) begin
            n_err++;
            $display("FAIL step_count inst=%0d cyc=%0d actual=%0d required=%0d", i, cyc, sc, m_cnt[i]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (bus_r.step === 1'b1) pulses_r++;
        if (bus_n.step === 1'b1) pulses_n++;
        check_one(0, bus_r.step, bus_r.pressed, bus_r.step_count);
        check_one(1, bus_n.step, bus_n.pressed, bus_n.step_count);
    end

    // Drive the button level now and keep it for n cycles.
    task automatic hold(input bit b, input int n);
        bus_r.btn = b;
        bus_n.btn = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        #1 rst_n = v;
    endtask

    initial begin
        int p0_r;
        int p0_n;
        rst_n     = 1'b0;
        bus_r.btn = 1'b1;
        bus_n.btn = 1'b1;
        @(negedge clk);

        // Button held through reset, then a normal press after release.
        hold(1'b1, 5);
        set_rst(1'b1);
        hold(1'b1, 20);
        hold(1'b0, 15);

        // Clean 6-cycle press.
        hold(1'b1, 6);
        hold(1'b0, 12);

        // Short glitches that must never be accepted.
        hold(1'b1, 1);
        hold(1'b0, 8);
        hold(1'b1, 3);
        hold(1'b0, 8);

        // Long hold: auto-repeat on one instance only.
        hold(1'b1, 40);
        hold(1'b0, 15);

        // Release bounce 1/0/1/0 in 2-cycle segments.
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 12);

        // Reset in the middle of a press debounce.
        hold(1'b1, 3);
        set_rst(1'b0);
        hold(1'b1, 3);
        set_rst(1'b1);
        hold(1'b0, 12);

        // Randomised button activity with mixed run lengths.
        for (int k = 0; k < 40; k++)
            hold(k[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 16)));
        hold(1'b0, 20);

        // 256 presses from a fresh reset: the count must wrap back to zero.
        set_rst(1'b0);
        hold(1'b0, 3);
        set_rst(1'b1);
        hold(1'b0, 3);
        p0_r = pulses_r;
        p0_n = pulses_n;
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        hold(1'b0, 4);

        n_cmp++;
        if (pulses_n - p0_n != 256) begin
            n_err++;
            $display("FAIL wrap_pulses_norep actual=%0d required=256", pulses_n - p0_n);
        end
        n_cmp++;
        if (pulses_r - p0_r != 256) begin
            n_err++;
            $display("FAIL wrap_pulses_rep actual=%0d required=256", pulses_r - p0_r);
        end
        n_cmp++;
        if (bus_n.step_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_count_norep actual=%0d required=0", bus_n.step_count);
        end
        n_cmp++;
        if (bus_r.step_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_count_rep actual=%0d required=0", bus_r.step_count);
        end
        n_cmp++;
        if (q_r.size() + q_n.size() != 0) begin
            n_err++;
            $display("FAIL pending_steps actual=%0d required=0", q_r.size() + q_n.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
